conv_out_streamer: RTL and testbench

//  Read side of the conv2 output matrix. Once conv2 asserts done, walks convIxKernelOut
//  row-major and emits one element per accepted beat on a valid/ready stream.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_out_streamer_if.sv | 26 ++
 rtl/conv_idx_counter.sv | 45 ++++
 rtl/conv_out_streamer.sv | 113 +++++++++++
 tb/tb_conv_out_streamer.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for conv2, the output streamer and their benches.
package conv_pkg;

  localparam int unsigned ElemWidth = 16;

  typedef logic signed [ElemWidth-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT_LOW
  } strm_state_t;

  function automatic int unsigned out_side(int unsigned size, int unsigned size_ker);
    return size - size_ker + 1;
  endfunction

  // Counter width that stays legal when the matrix degenerates to a single element.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_out_streamer_if.sv
// Valid/ready element stream with end-of-row and end-of-frame markers.
interface conv_out_streamer_if #(
  parameter int unsigned WIDTH_BIT = 16
);
  logic signed [WIDTH_BIT-1:0] m_data;
  logic                        m_valid;
  logic                        m_ready;
  logic                        m_last_col;
  logic                        m_last;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready,
    output m_last_col,
    output m_last
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready,
    input  m_last_col,
    input  m_last
  );
endinterface

// File: rtl/conv_idx_counter.sv
// Row-major row/col counter over an n x n matrix; exposes the next index so the
// caller can prefetch the following element in the same cycle as a beat.
module conv_idx_counter #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col,
  output logic [CW-1:0] nxt_row,
  output logic [CW-1:0] nxt_col,
  output logic          last_col,
  output logic          last
);
  localparam logic [CW-1:0] Max = CW'(N - 1);

  assign last_col = (col == Max);
  assign last     = last_col && (row == Max);

  always_comb begin
    nxt_col = col + 1'b1;
    nxt_row = row;
    if (last_col) begin
      nxt_col = '0;
      nxt_row = last ? '0 : row + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      row <= nxt_row;
      col <= nxt_col;
    end
  end

endmodule

// File: rtl/conv_out_streamer.sv
// Streams the conv2 result matrix row-major once done rises, one element per beat.
// Define CONV_OUT_RELU_EN to clamp negative elements to zero before the output register.
module conv_out_streamer
  import conv_pkg::*;
#(
  parameter int unsigned SIZE      = 320,
  parameter int unsigned SIZEKer   = 5,
  parameter int unsigned WIDTH_BIT = 16,
  localparam int unsigned OUT_N    = out_side(SIZE, SIZEKer)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        done,
  input  logic signed [WIDTH_BIT-1:0] convIxKernelOut [OUT_N][OUT_N],
  conv_out_streamer_if.master         m,
  output logic                        busy,
  output logic                        frame_done
);
  localparam int unsigned CW = cnt_width(OUT_N);

  strm_state_t state_q, state_d;

  logic [CW-1:0] row, col, nxt_row, nxt_col, sel_row, sel_col;
  logic          last_col, last, cnt_clr, cnt_en, load, frame_done_d;

  logic signed [WIDTH_BIT-1:0] elem_sel, data_d, data_q;

  conv_idx_counter #(
    .N  (OUT_N),
    .CW (CW)
  ) u_idx (
    .clock    (clock),
    .reset    (reset),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .row      (row),
    .col      (col),
    .nxt_row  (nxt_row),
    .nxt_col  (nxt_col),
    .last_col (last_col),
    .last     (last)
  );

  always_comb begin
    state_d      = state_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    load         = 1'b0;
    sel_row      = row;
    sel_col      = col;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Counter sits at [0][0] here, so the current index is the first element.
        cnt_clr = 1'b1;
        if (done) begin
          load    = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (m.m_ready) begin
          if (last) begin
            cnt_clr      = 1'b1;
            frame_done_d = 1'b1;
            state_d      = WAIT_LOW;
          end else begin
            cnt_en  = 1'b1;
            load    = 1'b1;
            sel_row = nxt_row;
            sel_col = nxt_col;
          end
        end
      end
      WAIT_LOW: begin
        if (!done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign elem_sel = convIxKernelOut[sel_row][sel_col];

`ifdef CONV_OUT_RELU_EN
  assign data_d = elem_sel[WIDTH_BIT-1] ? '0 : elem_sel;
`else
  assign data_d = elem_sel;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_done <= frame_done_d;
      if (load) data_q <= data_d;
    end
  end

  // The state register doubles as m_valid, so a reset drops the stream at once.
  assign m.m_valid    = (state_q == STREAM);
  assign m.m_data     = data_q;
  assign m.m_last_col = m.m_valid && last_col;
  assign m.m_last     = m.m_valid && last;
  assign busy         = m.m_valid;

  // The matrix is only guaranteed stable while done stays high.
  done_held_a: assert property (@(posedge clock) disable iff (reset)
    (state_q == STREAM) |-> done);

endmodule

// File: tb/tb_conv_out_streamer.sv
// Scoreboard bench for conv_out_streamer with a 4x4 output matrix (SIZE=6, SIZEKer=3).
module tb_conv_out_streamer;
  import conv_pkg::*;

  localparam int unsigned N = 4;

  typedef struct packed {
    logic [15:0] data;
    logic        lc;
    logic        l;
  } beat_t;

  logic  clock = 1'b0;
  logic  reset;
  logic  done;
  logic  busy;
  logic  frame_done;
  elem_t mat [N][N];

  conv_out_streamer_if #(.WIDTH_BIT(16)) m_if ();

  conv_out_streamer #(
    .SIZE      (6),
    .SIZEKer   (3),
    .WIDTH_BIT (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .done            (done),
    .convIxKernelOut (mat),
    .m               (m_if),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  always #5 clock = ~clock;

  beat_t       exp_q [$];
  int          total = 0;
  int          bad = 0;
  int          beat_cnt = 0;
  int          fd_cnt = 0;
  int          rmode = 0;
  logic [15:0] first_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference: every element in row-major order, markers from its coordinates.
  function automatic logic [15:0] model_elem(elem_t v);
`ifdef CONV_OUT_RELU_EN
    return (v < 0) ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic push_frame();
    beat_t e;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        e.data = model_elem(mat[r][c]);
        e.lc   = (c == N - 1);
        e.l    = (r == N - 1) && (c == N - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Ready driver: 0 = always, 1 = pattern 1,0,0,..., 2 = random.
  initial begin
    int cyc = 0;
    m_if.m_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      case (rmode)
        1:       m_if.m_ready = (cyc % 3 == 0);
        2:       m_if.m_ready = 1'($urandom_range(0, 1));
        default: m_if.m_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each beat and checks AXIS hold rules.
  initial begin
    logic  prev_stall = 1'b0;
    logic  fd_exp = 1'b0;
    beat_t held = '0;
    beat_t got, want;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 1'b0;
        fd_exp     = 1'b0;
      end else begin
        chk("frame_done_timing", 32'(frame_done), 32'(fd_exp));
        if (frame_done) fd_cnt++;
        fd_exp = 1'b0;
        got = {m_if.m_data, m_if.m_last_col, m_if.m_last};
        if (prev_stall) begin
          chk("valid_hold", 32'(m_if.m_valid), 32'd1);
          chk("stall_hold", 32'(got), 32'(held));
        end
        if (m_if.m_valid && m_if.m_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", 32'(beat_cnt), 32'hFFFF_FFFF);
          end else begin
            want = exp_q.pop_front();
            chk("beat_data", 32'(got.data), 32'(want.data));
            chk("beat_last_col", 32'(got.lc), 32'(want.lc));
            chk("beat_last", 32'(got.l), 32'(want.l));
            if (want.l) fd_exp = 1'b1;
          end
          if (beat_cnt == 0) first_data = got.data;
          beat_cnt++;
        end
        prev_stall = m_if.m_valid && !m_if.m_ready;
        held       = got;
      end
    end
  end

  task automatic start_frame(input int mode);
    rmode = mode;
    @(posedge clock);
    #1;
    done = 1'b0;
    @(posedge clock);
    #1;
    fd_cnt   = 0;
    beat_cnt = 0;
    push_frame();
    done = 1'b1;
    @(negedge clock);
    chk("latency_pre", 32'(m_if.m_valid), 32'd0);
    @(negedge clock);
    #1;
    chk("latency_valid", 32'(m_if.m_valid), 32'd1);
    chk("busy_on", 32'(busy), 32'd1);
  endtask

  task automatic wait_frame();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("frame_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    #1;
    chk("frame_done_once", 32'(fd_cnt), 32'd1);
    chk("busy_off", 32'(busy), 32'd0);
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mat[r][c] = elem_t'(4 * r + c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    int n;
    reset = 1'b1;
    done  = 1'b0;
    fill_ramp();
    #2;
    chk("reset_valid", 32'(m_if.m_valid), 32'd0);
    chk("reset_outs", {m_if.m_data, 13'd0, busy, frame_done, m_if.m_last | m_if.m_last_col},
        32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Basic frame, then the same data under backpressure.
    run_frame(0);
    run_frame(1);

    // done held high: no retrigger; a one-cycle drop restarts from [0][0].
    vcnt = 0;
    repeat (100) begin
      @(negedge clock);
      #1;
      if (m_if.m_valid) vcnt++;
    end
    chk("level_hold_no_frame", 32'(vcnt), 32'd0);
    run_frame(0);
    chk("restart_first", 32'(first_data), 32'd0);

    // Reset after the fifth accepted beat.
    start_frame(0);
    n = 0;
    while (beat_cnt < 5 && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("beats_before_reset", 32'(beat_cnt), 32'd5);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("reset_mid_valid", 32'(m_if.m_valid), 32'd0);
    chk("reset_mid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    done = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    run_frame(2);
    chk("after_reset_first", 32'(first_data), 32'd0);

    // Negative element.
    mat[0][0] = elem_t'(16'hFFFD);
    run_frame(1);
`ifdef CONV_OUT_RELU_EN
    chk("sign_first", 32'(first_data), 32'h0000);
`else
    chk("sign_first", 32'(first_data), 32'hFFFD);
`endif

    // Random matrices under random backpressure.
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) mat[r][c] = elem_t'($urandom_range(0, 65535));
      run_frame(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic run_frame(input int mode);
    start_frame(mode);
    wait_frame();
  endtask

endmodule
